// File: rtl/text_dma_sched.sv
// ---------------------------------------------------------------------------
// text_dma_sched
//
// Sequences the per-line glyph fetches for one row of text sprites. When a
// line is requested it walks the sprites in order. For each sprite it reads
// one code point from the greeting-message ROM. On the following cycle it
// presents that sprite's glyph-line address to the shared font ROM and
// raises the sprite's one-hot DMA strobe, so the sprite captures the font
// data.
//
// Ports
//   clk               pixel clock
//   rst               synchronous, active-high reset
//   start_i           one-cycle request to fetch for a line
//   msg_idx_i         greeting message selected (sampled with start_i)
//   row_i             0 = first half of message, 1 = second half
//   spr_pos_i         packed glyph-line index per sprite, sprite i at
//                     [i*LINEW +: LINEW] (sampled with start_i)
//   greet_rom_addr_o  greeting ROM address (ROM has 1-cycle read latency)
//   greet_rom_data_i  code point returned by the greeting ROM
//   font_rom_addr_o   font ROM address
//   spr_dma_o         one-hot: sprite i owns this cycle's font_rom_addr_o
//   busy_o            sequence in progress
//   done_o            one-cycle pulse on the first idle cycle after a sequence
//   overrun_o         sticky: start_i arrived while busy
//   clr_overrun_i     clears overrun_o (a coincident new overrun wins)
// ---------------------------------------------------------------------------
module text_dma_sched #(
    parameter int SPR_CNT      = 8,
    parameter int GREET_MSGS   = 32,
    parameter int GREET_LENGTH = 16,
    parameter int CP_W         = 7,
    parameter int CP_START     = 'h20,
    parameter int FONT_GLYPHS  = 64,
    parameter int FONT_HEIGHT  = 8,
    parameter int GADDRW       = $clog2(GREET_MSGS * GREET_LENGTH),
    parameter int FADDRW       = $clog2(FONT_GLYPHS * FONT_HEIGHT),
    parameter int LINEW        = $clog2(FONT_HEIGHT),
    parameter int MSGW         = $clog2(GREET_MSGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [MSGW-1:0]            msg_idx_i,
    input  logic                       row_i,
    input  logic [SPR_CNT*LINEW-1:0]   spr_pos_i,
    output logic [GADDRW-1:0]          greet_rom_addr_o,
    input  logic [CP_W-1:0]            greet_rom_data_i,
    output logic [FADDRW-1:0]          font_rom_addr_o,
    output logic [SPR_CNT-1:0]         spr_dma_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overrun_o,
    input  logic                       clr_overrun_i
);

    localparam int KW = $clog2(SPR_CNT + 1);
    localparam int SW = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;
    localparam int GW = (FONT_GLYPHS > 1) ? $clog2(FONT_GLYPHS) : 1;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [GADDRW-1:0]          base_q, base_d;
    logic [SPR_CNT*LINEW-1:0]   pos_q, pos_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            base_q    <= '0;
            pos_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Row 1 reads the second half of the message.
                    base_d  = GADDRW'(msg_idx_i) * GADDRW'(GREET_LENGTH)
                            + (row_i ? GADDRW'(GREET_LENGTH / 2) : '0);
                    pos_d   = spr_pos_i;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (k_q == KW'(SPR_CNT)) begin
                    // Last sprite is being served; done lands on the
                    // first idle cycle.
                    state_d = IDLE;
                    k_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Set takes priority over clear.
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (start_i && (state_q == FETCH)) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // The ROM answers one cycle after it is addressed. At count k the data
    // on greet_rom_data_i therefore belongs to sprite k-1.
    logic               serve_spr;
    logic [SW-1:0]      spr_j;
    logic [LINEW-1:0]   pos_arr [SPR_CNT];
    logic [GW-1:0]      glyph;

    assign serve_spr = (state_q == FETCH) && (k_q != '0);
    assign spr_j     = SW'(k_q - KW'(1));

    generate
        for (genvar gi = 0; gi < SPR_CNT; gi++) begin : g_spr
            assign pos_arr[gi]   = pos_q[gi*LINEW +: LINEW];
            assign spr_dma_o[gi] = serve_spr && (spr_j == SW'(gi));
        end
    endgenerate

    always_comb begin
        greet_rom_addr_o = '0;
        if ((state_q == FETCH) && (k_q < KW'(SPR_CNT))) begin
            greet_rom_addr_o = base_q + GADDRW'(k_q);
        end

        // Code points outside the font fall back to glyph 0 (blank).
        glyph = '0;
        if ((int'(greet_rom_data_i) >= CP_START) &&
            (int'(greet_rom_data_i) <  CP_START + FONT_GLYPHS)) begin
            glyph = GW'(int'(greet_rom_data_i) - CP_START);
        end

        font_rom_addr_o = '0;
        if (serve_spr) begin
            font_rom_addr_o = FADDRW'(int'(glyph) * FONT_HEIGHT + int'(pos_arr[spr_j]));
        end
    end

    assign busy_o    = (state_q == FETCH);
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_text_dma_sched.sv
module tb_text_dma_sched;

    localparam int NSPR  = 8;
    localparam int LW    = 3;
    localparam int NMEM  = 512;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [4:0]         msg_idx;
    logic               row;
    logic [23:0]        spr_pos;
    logic [8:0]         greet_rom_addr;
    logic [6:0]         greet_rom_data;
    logic [8:0]         font_rom_addr;
    logic [7:0]         spr_dma;
    logic               busy;
    logic               done;
    logic               overrun;
    logic               clr_overrun;

    always #5 clk = ~clk;

    text_dma_sched dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .msg_idx_i        (msg_idx),
        .row_i            (row),
        .spr_pos_i        (spr_pos),
        .greet_rom_addr_o (greet_rom_addr),
        .greet_rom_data_i (greet_rom_data),
        .font_rom_addr_o  (font_rom_addr),
        .spr_dma_o        (spr_dma),
        .busy_o           (busy),
        .done_o           (done),
        .overrun_o        (overrun),
        .clr_overrun_i    (clr_overrun)
    );

    // Greeting ROM: synchronous, one-cycle latency.
    logic [6:0] greet_mem [NMEM];
    always @(posedge clk) greet_rom_data <= greet_mem[greet_rom_addr];

    int  total = 0;
    int  bad   = 0;
    bit  exp_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void fill_mem();
        for (int i = 0; i < NMEM; i++) greet_mem[i] = 7'($urandom_range(0, 127));
    endfunction

    // Reference: what each output should be t cycles after the start was
    // sampled, from the sequencing rules (sprite j is served at t=j+2 with the
    // code point stored at base+j).
    function automatic void exp_at(input int t, input int base, input logic [23:0] pos,
                                   output int ga, output int fa, output int dm,
                                   output int bs, output int dn);
        int j, cp, g;
        ga = (t >= 1 && t <= NSPR) ? (base + t - 1) % NMEM : 0;
        fa = 0;
        dm = 0;
        if (t >= 2 && t <= NSPR + 1) begin
            j  = t - 2;
            cp = int'(greet_mem[(base + j) % NMEM]);
            g  = (cp >= 'h20 && cp < 'h20 + 64) ? cp - 'h20 : 0;
            fa = (g * 8 + int'(pos[j*LW +: LW])) % NMEM;
            dm = 1 << j;
        end
        bs = (t >= 1 && t <= NSPR + 1) ? 1 : 0;
        dn = (t == NSPR + 2) ? 1 : 0;
    endfunction

    // Runs one full sequence. On entry we are at the falling edge of the
    // cycle that will be T0 (or T1 if skip_t0, when the start was already
    // issued on the previous done cycle). Returns at the falling edge of
    // T(NSPR+3).
    task automatic run_seq(input int msg, input int rw, input logic [23:0] pos,
                           input int exp_base, input int exp_f2,
                           input int ovr_at, input int clr_at,
                           input bit chain, input bit skip_t0,
                           input int nmsg, input int nrow, input logic [23:0] npos);
        int base, ga, fa, dm, bs, dn;
        bit st, cl;
        base = (msg * 16 + rw * 8) % NMEM;
        if (!skip_t0) begin
            start = 1'b1; msg_idx = 5'(msg); row = 1'(rw); spr_pos = pos; clr_overrun = 1'b0;
            @(negedge clk);
        end
        for (int t = 1; t <= NSPR + 2; t++) begin
            exp_at(t, base, pos, ga, fa, dm, bs, dn);
            check($sformatf("greet_addr t%0d", t), greet_rom_addr, ga);
            check($sformatf("font_addr t%0d", t), font_rom_addr, fa);
            check($sformatf("spr_dma t%0d", t), spr_dma, dm);
            check($sformatf("busy t%0d", t), busy, bs);
            check($sformatf("done t%0d", t), done, dn);
            check($sformatf("overrun t%0d", t), overrun, exp_ovr);
            if (t == 1 && exp_base >= 0) check("base", greet_rom_addr, exp_base);
            if (t == 2 && exp_f2 >= 0)   check("font_t2", font_rom_addr, exp_f2);
            st = (t == ovr_at) || (chain && t == NSPR + 2);
            cl = (t == clr_at);
            start = st;
            clr_overrun = cl;
            if (chain && t == NSPR + 2) begin
                msg_idx = 5'(nmsg); row = 1'(nrow); spr_pos = npos;
            end else begin
                msg_idx = 5'($urandom_range(0, 31));
                row     = 1'($urandom_range(0, 1));
                spr_pos = 24'($urandom);
            end
            if (st && bs == 1)  exp_ovr = 1'b1;
            else if (cl)        exp_ovr = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        clr_overrun = 1'b0;
        $display("seq msg=%0d row=%0d base=%0d ovr_at=%0d clr_at=%0d chain=%0d overrun=%0d",
                 msg, rw, base, ovr_at, clr_at, chain, overrun);
    endtask

    task automatic idle_cycle(input bit cl);
        check("idle greet_addr", greet_rom_addr, 0);
        check("idle font_addr", font_rom_addr, 0);
        check("idle spr_dma", spr_dma, 0);
        check("idle busy", busy, 0);
        check("idle done", done, 0);
        check("idle overrun", overrun, exp_ovr);
        clr_overrun = cl;
        if (cl) exp_ovr = 1'b0;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    typedef struct {
        int          msg;
        int          rw;
        logic [23:0] pos;
        int          exp_base;
        int          exp_f2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c_msg, c_row, n_msg, n_row, ovr, clr;
        logic [23:0] c_pos, n_pos;
        bit chain, skip;

        rst = 1'b1; start = 1'b0; msg_idx = '0; row = 1'b0; spr_pos = '0; clr_overrun = 1'b0;
        fill_mem();
        greet_mem[56] = 7'h41;
        greet_mem[58] = 7'h7F;
        greet_mem[59] = 7'h10;

        // sprite positions: s0=5, s1=0, s2=4, s3=4, s4=4, s5=3, s6=2, s7=1
        vecs[0] = '{3,  1, 24'o12344405,     56, 269};
        vecs[1] = '{31, 1, 24'($urandom),   504, -1};
        vecs[2] = '{0,  0, 24'($urandom),     0, -1};
        vecs[3] = '{17, 0, 24'($urandom),   272, -1};
        vecs[4] = '{20, 1, 24'($urandom),   328, -1};

        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst overrun", overrun, 0);
        check("rst spr_dma", spr_dma, 0);
        check("rst greet_addr", greet_rom_addr, 0);
        check("rst font_addr", font_rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        idle_cycle(1'b0);

        // Table-driven sequences.
        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].msg, vecs[v].rw, vecs[v].pos, vecs[v].exp_base, vecs[v].exp_f2,
                    -1, -1, 1'b0, 1'b0, 0, 0, '0);
            idle_cycle(1'b0);
        end

        // Overrun at T4: sequence continues, overrun from T5; clear at T12.
        run_seq(3, 1, 24'o12344405, 56, 269, 4, -1, 1'b0, 1'b0, 0, 0, '0);
        idle_cycle(1'b0);              // T11
        idle_cycle(1'b1);              // T12, clr_overrun
        check("ovr cleared T13", overrun, 0);
        idle_cycle(1'b0);

        // Start and clear in the same busy cycle: set wins.
        run_seq(5, 0, 24'($urandom), 80, -1, 3, 3, 1'b0, 1'b0, 0, 0, '0);
        check("ovr set wins", overrun, 1);
        idle_cycle(1'b1);

        // Start on the done cycle is accepted as a new sequence.
        run_seq(6, 0, 24'($urandom), 96, -1, -1, -1, 1'b1, 1'b0, 7, 1, 24'o01234567);
        run_seq(7, 1, 24'o01234567, 120, -1, -1, -1, 1'b0, 1'b1, 0, 0, '0);
        idle_cycle(1'b0);

        // Reset during T5 aborts the sequence.
        start = 1'b1; msg_idx = 5'd3; row = 1'b0; spr_pos = 24'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check($sformatf("pre-rst busy t%0d", t), busy, 1);
            if (t == 5) rst = 1'b1;
            @(negedge clk);
        end
        exp_ovr = 1'b0;
        check("post-rst busy", busy, 0);
        check("post-rst spr_dma", spr_dma, 0);
        check("post-rst greet_addr", greet_rom_addr, 0);
        check("post-rst font_addr", font_rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) idle_cycle(1'b0);
        $display("reset mid-sequence done");
        run_seq(3, 0, 24'($urandom), 48, -1, -1, -1, 1'b0, 1'b0, 0, 0, '0);
        idle_cycle(1'b0);

        // Randomized sequences against the reference.
        skip  = 1'b0;
        c_msg = $urandom_range(0, 31);
        c_row = $urandom_range(0, 1);
        c_pos = 24'($urandom);
        for (int it = 0; it < 24; it++) begin
            n_msg = $urandom_range(0, 31);
            n_row = $urandom_range(0, 1);
            n_pos = 24'($urandom);
            chain = (it != 23) && ($urandom_range(0, 2) == 0);
            ovr   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NSPR + 1)) : -1;
            clr   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NSPR + 2)) : -1;
            run_seq(c_msg, c_row, c_pos, -1, -1, ovr, clr, chain, skip, n_msg, n_row, n_pos);
            if (!chain) begin
                fill_mem();
                repeat ($urandom_range(1, 3)) idle_cycle(1'($urandom_range(0, 1)));
            end
            skip  = chain;
            c_msg = n_msg;
            c_row = n_row;
            c_pos = n_pos;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
